// File: rtl/fp_ctrl_pkg.sv
// Shared constants and types for the FP add/sub front-end arbiter.
// Holds the default latency/width, op encodings and requester-id type.
package fp_ctrl_pkg;

    localparam int PIPE_LAT_DEF = 4;
    localparam int W_DEF        = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/fpaddsub_tagpipe.sv
// Tag delay line: DEPTH-deep shift register of {valid, id} with sync clear.
// Ports: clk, clr, in_valid/in_id (stage 0 input), out_valid/out_id (last stage).
module fpaddsub_tagpipe
    import fp_ctrl_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT_DEF
) (
    input  logic    clk,
    input  logic    clr,
    input  logic    in_valid,
    input  req_id_t in_id,
    output logic    out_valid,
    output req_id_t out_id
);

    logic [DEPTH-1:0] vld_d, vld_q;
    logic [DEPTH-1:0] id_d, id_q;

    always_comb begin
        vld_d    = vld_q;
        id_d     = id_q;
        vld_d[0] = in_valid;
        id_d[0]  = in_id;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/fpaddsub_arbiter.sv
// Two-requester round-robin front end for a fixed-latency FP add/sub pipe.
// Ports: req0/req1 valid/ready/a/b/op in, pipe_* issue out, pipe_result in,
// rsp0/rsp1 strobes with shared rsp_data, inflight count and busy flag.
module fpaddsub_arbiter
    import fp_ctrl_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int W        = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_op,
    output logic         pipe_valid,
    output logic [W-1:0] pipe_a,
    output logic [W-1:0] pipe_b,
    output logic         pipe_op,
    input  logic [W-1:0] pipe_result,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [W-1:0] rsp_data,
    output logic [3:0]   inflight,
    output logic         busy
);

    req_id_t      last_grant_d, last_grant_q;
    logic         pipe_valid_d, pipe_valid_q;
    logic [W-1:0] pipe_a_d, pipe_a_q;
    logic [W-1:0] pipe_b_d, pipe_b_q;
    logic         pipe_op_d, pipe_op_q;
    req_id_t      pipe_id_d, pipe_id_q;
    logic [3:0]   inflight_d, inflight_q;
    logic         tag_valid;
    req_id_t      tag_id;

    // Under contention the side that did not win last time takes the slot.
    assign req0_ready = !rst && req0_valid
                        && (!req1_valid || last_grant_q == REQ1);
    assign req1_ready = !rst && req1_valid
                        && (!req0_valid || last_grant_q == REQ0);

    always_comb begin
        last_grant_d = last_grant_q;
        pipe_valid_d = req0_ready || req1_ready;
        pipe_a_d     = pipe_a_q;
        pipe_b_d     = pipe_b_q;
        pipe_op_d    = pipe_op_q;
        pipe_id_d    = pipe_id_q;
        unique case (1'b1)
            req0_ready: begin
                last_grant_d = REQ0;
                pipe_a_d     = req0_a;
                pipe_b_d     = req0_b;
                pipe_op_d    = req0_op;
                pipe_id_d    = REQ0;
            end
            req1_ready: begin
                last_grant_d = REQ1;
                pipe_a_d     = req1_a;
                pipe_b_d     = req1_b;
                pipe_op_d    = req1_op;
                pipe_id_d    = REQ1;
            end
            default: ;
        endcase
    end

    // Counted from the registered issue, so steady state settles at PIPE_LAT.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({pipe_valid_q, tag_valid})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= REQ1;
            pipe_valid_q <= 1'b0;
            pipe_a_q     <= '0;
            pipe_b_q     <= '0;
            pipe_op_q    <= 1'b0;
            pipe_id_q    <= REQ0;
            inflight_q   <= 4'd0;
        end else begin
            last_grant_q <= last_grant_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_a_q     <= pipe_a_d;
            pipe_b_q     <= pipe_b_d;
            pipe_op_q    <= pipe_op_d;
            pipe_id_q    <= pipe_id_d;
            inflight_q   <= inflight_d;
        end
    end

    // Tag enters alongside pipe_valid, so it exits with pipe_result.
    fpaddsub_tagpipe #(
        .DEPTH(PIPE_LAT)
    ) u_tagpipe (
        .clk      (clk),
        .clr      (rst),
        .in_valid (pipe_valid_q),
        .in_id    (pipe_id_q),
        .out_valid(tag_valid),
        .out_id   (tag_id)
    );

    assign pipe_valid = pipe_valid_q;
    assign pipe_a     = pipe_a_q;
    assign pipe_b     = pipe_b_q;
    assign pipe_op    = pipe_op_q;
    assign rsp0_valid = !rst && tag_valid && tag_id == REQ0;
    assign rsp1_valid = !rst && tag_valid && tag_id == REQ1;
    assign rsp_data   = pipe_result;
    assign inflight   = inflight_q;
    assign busy       = inflight_q != 4'd0 || pipe_valid_q;

endmodule

// File: tb/tb_fpaddsub_arbiter.sv
// Bench for fpaddsub_arbiter: behavioural FP pipe, queue-based reference
// model with per-cycle compare, directed scenarios and random traffic.
module tb_fpaddsub_arbiter;

    localparam int L = 4;
    localparam int W = 32;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        int          t;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    logic r0v, r1v, r0op, r1op;
    logic [31:0] r0a, r0b, r1a, r1b;

    logic rdy0, rdy1, pv, pop, rsp0, rsp1, busy;
    logic [31:0] pa, pb, pres, rdat;
    logic [3:0] infl;

    logic s_rdy0, s_rdy1, s_pv, s_pop, s_rsp0, s_rsp1, s_busy;
    logic [31:0] s_pa, s_pb, s_pres, s_rdat;
    logic [3:0] s_infl;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fpaddsub_arbiter #(.PIPE_LAT(L), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(rdy0), .req0_a(r0a),
        .req0_b(r0b), .req0_op(r0op),
        .req1_valid(r1v), .req1_ready(rdy1), .req1_a(r1a),
        .req1_b(r1b), .req1_op(r1op),
        .pipe_valid(pv), .pipe_a(pa), .pipe_b(pb), .pipe_op(pop),
        .pipe_result(pres),
        .rsp0_valid(rsp0), .rsp1_valid(rsp1), .rsp_data(rdat),
        .inflight(infl), .busy(busy)
    );

    fpaddsub_arbiter #(.PIPE_LAT(1), .W(W)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(s_rdy0), .req0_a(r0a),
        .req0_b(r0b), .req0_op(r0op),
        .req1_valid(r1v), .req1_ready(s_rdy1), .req1_a(r1a),
        .req1_b(r1b), .req1_op(r1op),
        .pipe_valid(s_pv), .pipe_a(s_pa), .pipe_b(s_pb), .pipe_op(s_pop),
        .pipe_result(s_pres),
        .rsp0_valid(s_rsp0), .rsp1_valid(s_rsp1), .rsp_data(s_rdat),
        .inflight(s_infl), .busy(s_busy)
    );

    // Integer-valued single-precision helpers (values well below 2^23).
    function automatic int f2i(logic [31:0] f);
        int e;
        int m;
        if (f[30:0] == 31'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = int'({1'b1, f[22:0]});
        m = m >>> (23 - e);
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] i2f(int v);
        logic s;
        int mag;
        int p;
        logic [31:0] m;
        if (v == 0) return 32'd0;
        s = v < 0;
        mag = s ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) if (mag[i]) p = i;
        m = 32'(mag) << (23 - p);
        return {s, 8'(p + 127), m[22:0]};
    endfunction

    function automatic logic [31:0] fpaddsub(logic [31:0] a, logic [31:0] b,
                                             logic op);
        return i2f(op ? f2i(a) - f2i(b) : f2i(a) + f2i(b));
    endfunction

    // Behavioural FP pipelines of depth L and 1.
    logic [31:0] pr [L];
    logic [31:0] s_pr;

    always @(posedge clk) begin
        pr[0] <= pv ? fpaddsub(pa, pb, pop) : 32'hDEAD_BEEF;
        for (int i = 1; i < L; i++) pr[i] <= pr[i-1];
        s_pr <= s_pv ? fpaddsub(s_pa, s_pb, s_pop) : 32'hDEAD_BEEF;
    end

    assign pres   = pr[L-1];
    assign s_pres = s_pr;

    task automatic chk1(string nm, logic act, logic exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        else
            passed++;
    endtask

    task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            passed++;
    endtask

    // Reference model, updated and compared once per cycle.
    int cyc = 0;
    logic lastg = 1'b1;
    logic epv = 1'b0;
    logic [31:0] epa = 32'd0;
    logic [31:0] epb = 32'd0;
    logic epop = 1'b0;
    op_t q[$];

    always @(negedge clk) begin : cmp
        logic e0, e1, er0, er1;
        int n;
        op_t o;
        if (rst) begin
            chk1("rst_rdy0", rdy0, 1'b0);
            chk1("rst_rdy1", rdy1, 1'b0);
            chk1("rst_rsp0", rsp0, 1'b0);
            chk1("rst_rsp1", rsp1, 1'b0);
            q.delete();
            lastg = 1'b1;
            epv = 1'b0;
            epa = 32'd0;
            epb = 32'd0;
            epop = 1'b0;
        end else begin
            e0 = r0v && (!r1v || lastg);
            e1 = r1v && (!r0v || !lastg);
            chk1("rdy0", rdy0, e0);
            chk1("rdy1", rdy1, e1);
            chk1("pipe_valid", pv, epv);
            chk32("pipe_a", pa, epa);
            chk32("pipe_b", pb, epb);
            chk1("pipe_op", pop, epop);
            n = 0;
            foreach (q[i]) if (q[i].t <= cyc - 2) n++;
            chk32("inflight", {28'd0, infl}, 32'(n));
            chk1("busy", busy, n != 0 || epv);
            er0 = 1'b0;
            er1 = 1'b0;
            if (q.size() > 0 && q[0].t + 1 + L == cyc) begin
                o = q.pop_front();
                er0 = !o.id;
                er1 = o.id;
                chk32("rsp_data", rdat, fpaddsub(o.a, o.b, o.op));
            end
            chk1("rsp0", rsp0, er0);
            chk1("rsp1", rsp1, er1);
            epv = e0 || e1;
            if (epv) begin
                o.id = e1;
                o.a  = e1 ? r1a : r0a;
                o.b  = e1 ? r1b : r0b;
                o.op = e1 ? r1op : r0op;
                o.t  = cyc;
                q.push_back(o);
                lastg = e1;
                epa = o.a;
                epb = o.b;
                epop = o.op;
            end
        end
        cyc++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r0v = 1'b0;
        r1v = 1'b0;
    endtask

    task automatic rnd_ops();
        r0a = i2f(int'($urandom_range(1, 1000)));
        r0b = i2f(int'($urandom_range(1, 1000)));
        r1a = i2f(int'($urandom_range(1, 1000)));
        r1b = i2f(int'($urandom_range(1, 1000)));
        r0op = 1'($urandom_range(0, 1));
        r1op = 1'($urandom_range(0, 1));
    endtask

    task automatic do_rst();
        rst = 1'b1;
        idle();
        @(negedge clk);
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        r0a = 32'd0; r0b = 32'd0; r1a = 32'd0; r1b = 32'd0;
        r0op = 1'b0; r1op = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;

        @(negedge clk);
        chk1("reset_pv", pv, 1'b0);
        chk32("reset_pa", pa, 32'd0);
        chk32("reset_infl", {28'd0, infl}, 32'd0);
        chk1("reset_busy", busy, 1'b0);
        nxt();

        // Single request: 1.0 + 2.0.
        r0v = 1'b1; r0a = 32'h3F80_0000; r0b = 32'h4000_0000; r0op = 1'b0;
        @(negedge clk);
        chk1("d1_rdy0", rdy0, 1'b1);
        nxt();
        r0v = 1'b0;
        @(negedge clk);
        chk1("d1_pv", pv, 1'b1);
        chk32("d1_pa", pa, 32'h3F80_0000);
        nxt();
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) begin
                chk1("d1_lat1_rsp0", s_rsp0, 1'b1);
                chk32("d1_lat1_data", s_rdat, 32'h4040_0000);
            end
            chk1("d1_rsp0", rsp0, k == 5);
            chk1("d1_rsp1", rsp1, 1'b0);
            if (k == 5) chk32("d1_data", rdat, 32'h4040_0000);
            nxt();
        end

        // Contention after reset: grants and responses alternate from req0.
        do_rst();
        for (int k = 0; k < 12; k++) begin
            if (k < 6) begin
                rnd_ops();
                r0v = 1'b1;
                r1v = 1'b1;
            end else begin
                idle();
            end
            @(negedge clk);
            if (k < 6) begin
                chk1("d2_gnt0", rdy0, (k % 2) == 0);
                chk1("d2_gnt1", rdy1, (k % 2) == 1);
            end
            if (k >= 5 && k <= 10) begin
                chk1("d2_rsp0", rsp0, ((k - 5) % 2) == 0);
                chk1("d2_rsp1", rsp1, ((k - 5) % 2) == 1);
            end
            nxt();
        end

        // Four back-to-back subtracts from req1: 3.0 - 1.0.
        for (int k = 0; k < 10; k++) begin
            r1v = k < 4;
            r1a = 32'h4040_0000; r1b = 32'h3F80_0000; r1op = 1'b1;
            @(negedge clk);
            if (k == 5) chk32("d3_infl4", {28'd0, infl}, 32'd4);
            if (k >= 5 && k <= 8) begin
                chk1("d3_rsp1", rsp1, 1'b1);
                chk32("d3_data", rdat, 32'h4000_0000);
            end
            if (k == 9) chk32("d3_infl0", {28'd0, infl}, 32'd0);
            nxt();
        end

        // Sustained issue: inflight must sit at 4 while issue and return overlap.
        for (int k = 0; k < 15; k++) begin
            rnd_ops();
            r0v = k < 12;
            @(negedge clk);
            if (k >= 5 && k <= 13) begin
                chk32("d4_infl", {28'd0, infl}, 32'd4);
                chk1("d4_busy", busy, 1'b1);
            end
            nxt();
        end

        // Reset with three operations in flight.
        for (int k = 0; k < 14; k++) begin
            rnd_ops();
            idle();
            rst = k == 4;
            if (k == 0 || k == 2) r0v = 1'b1;
            if (k == 1) r1v = 1'b1;
            if (k == 13) begin
                r0v = 1'b1;
                r1v = 1'b1;
            end
            @(negedge clk);
            if (k == 4) chk32("d5_infl3", {28'd0, infl}, 32'd3);
            if (k >= 5 && k <= 12) begin
                chk1("d5_no_rsp0", rsp0, 1'b0);
                chk1("d5_no_rsp1", rsp1, 1'b0);
                chk32("d5_infl0", {28'd0, infl}, 32'd0);
            end
            if (k == 13) begin
                chk1("d5_gnt0", rdy0, 1'b1);
                chk1("d5_gnt1", rdy1, 1'b0);
            end
            nxt();
        end
        rst = 1'b0;
        idle();

        // Random traffic with occasional reset.
        for (int n = 0; n < 3000; n++) begin
            rnd_ops();
            rst = $urandom_range(0, 199) == 0;
            r0v = $urandom_range(0, 3) != 0;
            r1v = $urandom_range(0, 3) != 0;
            nxt();
        end
        rst = 1'b0;
        idle();
        for (int n = 0; n < 12; n++) nxt();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fpaddsub_arbiter.md
FPADDSUB_ARBITER -- requirements
Module: fpaddsub_arbiter

Interface
REQ-001 Parameter PIPE_LAT, default 4: fixed latency in cycles from pipe_valid to pipe_result, legal range 1-8.
REQ-002 Parameter W, default 32: operand and result width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req0_valid / req1_valid  input  1  requester n offers an operation.
REQ-006 req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  W  operands.
REQ-008 req0_op / req1_op  input  1  0 = add, 1 = subtract.
REQ-009 pipe_valid  output  1  operation issued to the FP add/sub pipeline this cycle.
REQ-010 pipe_a, pipe_b  output  W  operands to the pipeline, registered.
REQ-011 pipe_op  output  1  operation code to the pipeline, registered.
REQ-012 pipe_result  input  W  pipeline result, valid PIPE_LAT cycles after the matching pipe_valid.
REQ-013 rsp0_valid / rsp1_valid  output  1  one-cycle result strobe to requester n; there is no backpressure.
REQ-014 rsp_data  output  W  result, shared by both requesters and qualified by rspN_valid.
REQ-015 inflight  output  4  count of operations issued but not yet returned.
REQ-016 busy  output  1  high when inflight != 0 or pipe_valid is high.

Function
REQ-017 Handshake: a transfer occurs when reqN_valid and reqN_ready are both high.
REQ-018 At most one of req0_ready or req1_ready is high in any cycle.
REQ-019 reqN_ready is combinational from reqN_valid and the arbitration state.
REQ-020 Arbitration rules:
- Single valid requester: that requester is granted.
- Both valid: the requester not granted most recently (last_grant) is granted; round-robin.
- Neither valid: no grant.
REQ-021 last_grant updates only on a transfer; its reset value is 1, so req0 wins the first contention.
REQ-022 On a transfer, pipe_a, pipe_b, pipe_op and pipe_valid register the winner's fields on the next edge, giving 1-cycle issue latency.
REQ-023 With no transfer, pipe_valid is 0 and pipe_a, pipe_b, pipe_op hold their previous values.
REQ-024 Throughput: one issue per cycle, sustained, with no bubbles.
REQ-025 Tag delay line of depth PIPE_LAT carries {valid, id}, where id is the granted requester, aligned with pipe_valid.
REQ-026 Return path: when the tag delay line output is valid, rsp<id>_valid pulses for one cycle and rsp_data = pipe_result, both combinational in that cycle.
REQ-027 End-to-end latency: a request accepted in cycle t produces its rsp in cycle t+1+PIPE_LAT.
REQ-028 inflight counts +1 on each issue and -1 on each return; an issue and a return in the same cycle leave it unchanged.
REQ-029 inflight never exceeds PIPE_LAT and never underflows.
REQ-030 Results return in issue order, and each result is routed only to the requester that issued it.

Reset
REQ-031 rst asserted for 1 or more cycles sets the following to 0: pipe_valid, pipe_a, pipe_b, pipe_op, every tag valid bit, inflight, rsp0_valid, rsp1_valid.
REQ-032 rst asserted for 1 or more cycles sets last_grant to 1.
REQ-033 Reset mid-operation discards every in-flight tag; no rsp strobe fires for any operation issued before reset, even though the pipeline still emits its data.
REQ-034 While rst is high, req0_ready and req1_ready are 0.

Structure
REQ-035 Package fp_ctrl_pkg holds:
- the PIPE_LAT default;
- the W default;
- the op encodings OP_ADD = 0 and OP_SUB = 1;
- the requester-id type (1 bit).
REQ-036 Sub-module fpaddsub_tagpipe implements the tag delay line: a parameterised shift register of depth PIPE_LAT with synchronous clear.
REQ-037 The arbiter, issue registers and inflight counter reside in fpaddsub_arbiter.
REQ-038 The bench models the pipeline as a PIPE_LAT-deep behavioural FP adder.

Verification
REQ-039 Single request: req0 offers 0x3F800000 + 0x40000000 (op=0) at cycle 0 -> req0_ready=1 at cycle 0, pipe_valid at cycle 1, rsp0_valid=1 with rsp_data=0x40400000 at cycle 5, rsp1_valid stays 0.
REQ-040 Contention: both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1, and responses alternate in the same order from cycle 5.
REQ-041 Back-to-back: req1 issues 4 consecutive subtracts, 0x40400000 - 0x3F800000 -> inflight reaches 4; four rsp1 strobes each carry 0x40000000; inflight returns to 0.
REQ-042 Simultaneous issue and return at steady state -> inflight holds at 4 with no glitch.
REQ-043 rst pulsed for 1 cycle with 3 operations in flight -> no rsp strobes follow, inflight=0, and the next contention grants req0.
REQ-044 PIPE_LAT=1 build with a single request -> rsp at cycle t+2.
